ahb_param_arbiter: RTL
======================

Name: ahb_param_arbiter

Overview:
Parametrised AHB (AMBA 2) bus arbiter for NO_OF_MASTERS masters. It selects the owner of the shared address/control bus, drives HGRANT, HMASTER and HMASTLOCK, and holds ownership across fixed-length bursts and locked sequences. It tracks SPLIT responses per master and releases them on HSPLIT. Compared with the existing fixed arbiter, it adds a selectable fixed-priority or round-robin policy, burst-aware re-arbitration and a split mask.

Parameters:
NO_OF_MASTERS, 4, number of masters (2..16)
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
DEFAULT_MASTER, 0, master granted when no eligible request is present; also the reset owner
MW, $clog2(NO_OF_MASTERS), HMASTER width (derived; not overridden)

Ports:
HCLK  input  1  bus clock, all logic on rising edge
HRESETn  input  1  asynchronous, active-low reset
HBUSREQ  input  NO_OF_MASTERS  per-master bus request
HLOCK  input  NO_OF_MASTERS  per-master locked-transfer request
HTRANS  input  2  current transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HBURST  input  3  burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
HREADY  input  1  transfer complete
HRESP  input  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3)
HSPLIT  input  NO_OF_MASTERS  split-completion strobe per master
HGRANT  output  NO_OF_MASTERS  one-hot grant, registered
HMASTER  output  MW  address-phase owner index
HMASTLOCK  output  1  current transfer is part of a locked sequence
split_mask  output  NO_OF_MASTERS  masters currently parked by SPLIT (debug/coverage)

Behaviour:
- Reset (async on HRESETn=0):
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0; split_mask = 0; beat counter = 0.
  - data-phase owner = DEFAULT_MASTER; round-robin pointer = DEFAULT_MASTER.
  - Reset mid-burst or mid-lock abandons all state immediately.
- Eligible set = HBUSREQ & ~split_mask.
- Fixed mode: lowest eligible index wins.
- Round-robin mode: search starts at (last granted index + 1) mod NO_OF_MASTERS and wraps; the pointer updates only when the grant changes.
- If the eligible set is empty, grant DEFAULT_MASTER, even if it is split-masked (it then drives IDLE).
- Re-arbitration occurs on a rising edge with HREADY=1 unless a hold condition is active:
  - (a) HLOCK[granted]=1;
  - (b) beat counter > 1 (fixed burst still issuing).
  - While held, HGRANT is unchanged.
- Beat counter:
  - On NONSEQ with HREADY=1, load 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16; load 0 for SINGLE and INCR.
  - On SEQ with HREADY=1, decrement if > 0.
  - BUSY and IDLE leave the counter unchanged.
  - INCR (undefined length) never holds; it may lose the bus at any HREADY edge.
- Early termination: HRESP = ERROR, RETRY or SPLIT while HREADY=0 (first response cycle) clears the beat counter.
- Latency:
  - HBUSREQ sampled at edge t gives HGRANT at edge t (visible after t).
  - HMASTER and HMASTLOCK update at the first edge with HREADY=1 at or after the grant change: HMASTER <= index(HGRANT), HMASTLOCK <= HLOCK[index(HGRANT)].
  - HMASTER, when it updates, is copied to the data-phase owner register on the following HREADY=1 edge.
- Split mask:
  - HRESP=SPLIT with HREADY=1 (second response cycle) sets split_mask[data-phase owner].
  - HSPLIT[i]=1 clears split_mask[i].
  - Set and clear on the same bit in the same cycle: set wins.
  - A SPLIT response to a locked master still sets the mask; that master's lock hold is dropped and re-arbitration proceeds.
- HREADY=0: no output changes except split_mask clears from HSPLIT and the beat-counter clear above.
- HGRANT is always exactly one-hot; HMASTER always < NO_OF_MASTERS.

Test Plan:
- N=4, fixed mode, after reset HBUSREQ=4'b1010 -> next edge HGRANT=4'b0010; HMASTER=1 at the first edge with HREADY=1.
- Round-robin, HBUSREQ=4'b1111 held, SINGLE NONSEQ every cycle with HREADY=1 -> grant sequence 1,2,3,0,1.
- Master 2 issues INCR8 (NONSEQ + 7 SEQ) while master 0 requests, fixed mode -> HGRANT stays 4'b0100 until the 8th beat address is accepted, then 4'b0001.
- Master 3 with HLOCK=1 and HBUSREQ=4'b1001, fixed mode -> grant held at 3 and HMASTLOCK=1 until HLOCK[3] drops; master 0 is granted on the next HREADY=1 edge.
- Master 1 receives SPLIT (HREADY 0 then 1) -> split_mask=4'b0010 and master 1 is skipped despite HBUSREQ[1]=1; HSPLIT=4'b0010 clears the mask and master 1 becomes eligible next edge.
- HRESETn pulled low mid-WRAP4 of master 2 -> all outputs return to reset values asynchronously; the first grant after reset follows normal arbitration.

Source files
------------

// File: rtl/ahb_param_arbiter.sv
// AHB (AMBA 2) bus arbiter: fixed-priority or round-robin grant, burst/lock hold,
// split masking, and address/data-phase owner tracking.
module ahb_param_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int ARB_MODE       = 0,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NO_OF_MASTERS)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic                     HREADY,
    input  logic [1:0]               HRESP,
    input  logic [NO_OF_MASTERS-1:0] HSPLIT,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]            HMASTER,
    output logic                     HMASTLOCK,
    output logic [NO_OF_MASTERS-1:0] split_mask
);

    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_SPLIT = 2'd3;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0] DEF_GNT =
        {{(NO_OF_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    logic [NO_OF_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]            grant_idx_q, grant_idx_d;
    logic [MW-1:0]            hmaster_q, hmaster_d;
    logic                     hmastlock_q, hmastlock_d;
    logic [MW-1:0]            owner_q, owner_d;
    logic [NO_OF_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [4:0]               beat_cnt_q, beat_cnt_d;

    logic [NO_OF_MASTERS-1:0] eligible;
    logic [MW-1:0]            arb_idx;
    logic [MW-1:0]            cand;
    logic                     arb_found;
    logic                     split_now;
    logic                     lock_hold;
    logic                     burst_hold;
    int                       j;

    // Beat down-counter: loaded with the fixed burst length on NONSEQ.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (HREADY) begin
            if (HTRANS == TR_NONSEQ) begin
                case (HBURST)
                    3'd2, 3'd3: beat_cnt_d = 5'd4;
                    3'd4, 3'd5: beat_cnt_d = 5'd8;
                    3'd6, 3'd7: beat_cnt_d = 5'd16;
                    default:    beat_cnt_d = 5'd0;
                endcase
            end else if (HTRANS == TR_SEQ && beat_cnt_q != 5'd0) begin
                beat_cnt_d = beat_cnt_q - 5'd1;
            end
        end else if (HRESP != RESP_OKAY) begin
            beat_cnt_d = 5'd0;
        end
    end

    always_comb begin
        split_now    = HREADY && (HRESP == RESP_SPLIT);
        split_mask_d = split_mask_q & ~HSPLIT;
        if (split_now) split_mask_d[owner_q] = 1'b1;
    end

    // The round-robin pointer is the current grant index: it moves exactly when the grant does.
    always_comb begin
        eligible  = HBUSREQ & ~split_mask_q;
        arb_idx   = DEF_IDX;
        arb_found = 1'b0;
        cand      = '0;
        j         = 0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NO_OF_MASTERS; i++) begin
                cand = MW'(i);
                if (!arb_found && eligible[cand]) begin
                    arb_idx   = cand;
                    arb_found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NO_OF_MASTERS; k++) begin
                j    = (int'(grant_idx_q) + k) % NO_OF_MASTERS;
                cand = MW'(j);
                if (!arb_found && eligible[cand]) begin
                    arb_idx   = cand;
                    arb_found = 1'b1;
                end
            end
        end
    end

    // A split owner loses its lock hold so the bus can move on.
    always_comb begin
        lock_hold  = HLOCK[grant_idx_q] && !split_mask_q[grant_idx_q] &&
                     !(split_now && owner_q == grant_idx_q);
        burst_hold = beat_cnt_d > 5'd1;

        grant_idx_d = grant_idx_q;
        if (HREADY && !lock_hold && !burst_hold) grant_idx_d = arb_idx;

        hgrant_d              = '0;
        hgrant_d[grant_idx_d] = 1'b1;

        hmaster_d   = HREADY ? grant_idx_q : hmaster_q;
        hmastlock_d = HREADY ? HLOCK[grant_idx_q] : hmastlock_q;
        owner_d     = HREADY ? hmaster_q : owner_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_q     <= DEF_GNT;
            grant_idx_q  <= DEF_IDX;
            hmaster_q    <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            owner_q      <= DEF_IDX;
            split_mask_q <= '0;
            beat_cnt_q   <= 5'd0;
        end else begin
            hgrant_q     <= hgrant_d;
            grant_idx_q  <= grant_idx_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            owner_q      <= owner_d;
            split_mask_q <= split_mask_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign HGRANT     = hgrant_q;
    assign HMASTER    = hmaster_q;
    assign HMASTLOCK  = hmastlock_q;
    assign split_mask = split_mask_q;

endmodule
